alu_issue: RTL and testbench
============================

# alu_issue

Issue and writeback controller on the driving side of the 16-bit ALU. It accepts packed register-register instructions over a valid/ready handshake and holds an 8-entry register file. It drives the ALU's operand and opcode inputs from pipeline flops, then captures the ALU result and overflow flag back into architectural state. It sits between the instruction source and the combinational ALU, and is the only agent that drives the ALU.

## Interface
- `INPUT_WIDTH`, 16, datapath width; must match the ALU.
- `NREGS`, 8, register-file depth; fixed at 8 because of the 3-bit fields.
- `clk`, in, 1, rising-edge clock.
- `reset`, in, 1: reset is synchronous and active-high.
- `instr_valid`, in, 1, instruction present.
- `instr_data`, in, 16, fields: [15:12] cop, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
- `instr_ready`, out, 1, block accepts the instruction this cycle.
- `alu_reg_A`, out, INPUT_WIDTH, ALU operand A.
- `alu_reg_B`, out, INPUT_WIDTH, ALU operand B.
- `alu_cop`, out, 4, ALU opcode.
- `alu_result`, in, INPUT_WIDTH, ALU result.
- `alu_OVF`, in, 1, ALU carry/borrow-out.
- `rd_addr`, in, 3, debug read address.
- `rd_data`, out, INPUT_WIDTH, combinational read of `regs[rd_addr]`.
- `ovf_flag`, out, 1, sticky overflow.
- `illegal_flag`, out, 1, sticky illegal-opcode flag.
- `clear_flags`, in, 1, clears both sticky flags.
- `busy`, out, 1, high when stage D or stage E is valid.

## Operation
- Two stages:
  - D: decode register, holds the accepted instruction.
  - E: ALU-driving flops plus writeback.
- Handshake:
  - Transfer occurs when `instr_valid && instr_ready`.
  - `instr_ready = !d_valid || advance`. It depends only on internal state, never on `instr_data`.
- Advance rule: `advance = d_valid && !hazard`. On advance, the regfile is read at D.ra and D.rb and the result is loaded into E.
- Hazard: `e_valid && e_wb && (E.rd == D.ra || E.rd == D.rb)`.
- Writeback, at the end of each cycle in which E is valid:
  - `regs[E.rd] <= alu_result`.
  - `ovf_flag` is set if `alu_OVF`.
- Legal cop values are 0000, 0001, 0010, 0011, 0100, 0110, 0111, 1110, 1111. For all of them `e_wb = 1`.
- Any other cop is illegal:
  - It is still issued to the ALU.
  - `e_wb = 0`, so neither the regfile nor `ovf_flag` is written.
  - `illegal_flag` is set when the instruction is in E.
- When E is empty, the ALU outputs are `alu_cop = 0000` and both operands are 0, so the ALU result is 0.
- Simultaneous sticky-flag set and `clear_flags` in the same cycle: set wins.
- Register 0 is a normal, writable register.
- Reset values:
  - All regs 0; `d_valid = e_valid = 0`.
  - `alu_cop`, `alu_reg_A`, `alu_reg_B` all 0.
  - `ovf_flag = illegal_flag = 0`.
  - `instr_ready = 1`, `busy = 0`.
- Reset asserted mid-operation discards D and E contents without any writeback in that cycle.

## Timing
- An instruction accepted in cycle N is in D during N+1 and drives the ALU from E during N+2.
- The regfile is written at the end of N+2, so `rd_data` reflects the new value from N+3.
- Throughput is one instruction per cycle for independent instructions.
- Back-to-back dependent instructions (without forwarding): D stalls one cycle, `instr_ready` is low for that cycle, and one bubble enters E.
- A dependency at distance 2 or more never stalls, because the regfile write precedes the read.

## Configuration
- `ALU_ISSUE_FWD_EN`: when defined, the hazard term is forced to 0.
  - On advance, any operand whose address matches a valid, writing E.rd takes `alu_result` instead of the regfile value.
  - Dependent back-to-back instructions then issue without a bubble.
- When undefined, hazards stall as described under Timing.
- Architectural results are identical in both builds; only cycle counts differ.

## Structure
- Shared package `alu_pkg` holds:
  - cop localparams: `COP_ZERO`, `COP_ADD`, `COP_SUB`, `COP_PASSB`, `COP_EQ`, `COP_ADD6`, `COP_ADD7`, `COP_ADDE`, `COP_ADDF`.
  - `is_legal_cop` function.
  - Instruction field slice constants.
  - Instruction struct typedef.
- One sub-module, `alu_issue_regfile`: 8×INPUT_WIDTH, two combinational read ports plus the debug port, one synchronous write port, synchronous reset to 0.

## Test plan
- Reset, then ADD r1=r0+r0 (cop 0001, rd1, ra0, rb0) → `regs[1] = 0` at N+3, `ovf_flag = 0`, `busy` low after E drains.
- Seed r2=FFFF and r3=0001 via the ALU stub; then ADD r4=r2+r3 → `regs[4] = 0000`, `ovf_flag = 1`. Then `clear_flags` → `ovf_flag = 0`.
- SUB r5=r3-r2 (1 - FFFF) → `regs[5] = 0002` and `ovf_flag = 1`, from borrow bit 16 set.
- Dependent pair ADD r1=r2+r3, then EQ r6=r1,r1 on consecutive cycles:
  - Without FWD: `instr_ready` is low for exactly one cycle and `regs[6] = 1`.
  - With FWD: no stall and `regs[6] = 1`.
- Illegal cop 1000 targeting r7 → `regs[7]` unchanged, `illegal_flag = 1`, `alu_cop = 1000` during its E cycle.
- `reset` asserted while both D and E are valid → no regfile write in that cycle, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: opcodes, instruction
// field positions and the decoded instruction record.
package alu_pkg;

   localparam logic [3:0] COP_ZERO  = 4'b0000;
   localparam logic [3:0] COP_ADD   = 4'b0001;
   localparam logic [3:0] COP_SUB   = 4'b0010;
   localparam logic [3:0] COP_PASSB = 4'b0011;
   localparam logic [3:0] COP_EQ    = 4'b0100;
   localparam logic [3:0] COP_ADD6  = 4'b0110;
   localparam logic [3:0] COP_ADD7  = 4'b0111;
   localparam logic [3:0] COP_ADDE  = 4'b1110;
   localparam logic [3:0] COP_ADDF  = 4'b1111;

   localparam int COP_MSB = 15;
   localparam int COP_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RA_MSB  = 8;
   localparam int RA_LSB  = 6;
   localparam int RB_MSB  = 5;
   localparam int RB_LSB  = 3;

   typedef struct packed {
      logic [3:0] cop;
      logic [2:0] rd;
      logic [2:0] ra;
      logic [2:0] rb;
   } instr_t;

   function automatic logic is_legal_cop(input logic [3:0] cop);
      logic legal;
      legal = 1'b0;
      case (cop)
         COP_ZERO, COP_ADD, COP_SUB, COP_PASSB, COP_EQ,
         COP_ADD6, COP_ADD7, COP_ADDE, COP_ADDF: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two operand read ports, one debug read port and a
// single synchronous write port, all cleared by synchronous reset.
module alu_issue_regfile #(
   parameter int INPUT_WIDTH = 16,
   parameter int NREGS       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   writeEn_i,
   input  logic [2:0]             writeAddr_i,
   input  logic [INPUT_WIDTH-1:0] writeData_i,
   input  logic [2:0]             readAddrA_i,
   output logic [INPUT_WIDTH-1:0] readDataA_o,
   input  logic [2:0]             readAddrB_i,
   output logic [INPUT_WIDTH-1:0] readDataB_o,
   input  logic [2:0]             dbgAddr_i,
   output logic [INPUT_WIDTH-1:0] dbgData_o
);

   logic [INPUT_WIDTH-1:0] regs_q [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (writeEn_i) begin
         regs_q[writeAddr_i] <= writeData_i;
      end
   end

   assign readDataA_o = regs_q[readAddrA_i];
   assign readDataB_o = regs_q[readAddrB_i];
   assign dbgData_o   = regs_q[dbgAddr_i];

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback controller driving a combinational 16-bit ALU.
// Define ALU_ISSUE_FWD_EN to forward the ALU result instead of stalling on hazards.
module alu_issue
   import alu_pkg::*;
#(
   parameter int INPUT_WIDTH = 16,
   parameter int NREGS       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   instr_valid,
   input  logic [15:0]            instr_data,
   output logic                   instr_ready,
   output logic [INPUT_WIDTH-1:0] alu_reg_A,
   output logic [INPUT_WIDTH-1:0] alu_reg_B,
   output logic [3:0]             alu_cop,
   input  logic [INPUT_WIDTH-1:0] alu_result,
   input  logic                   alu_OVF,
   input  logic [2:0]             rd_addr,
   output logic [INPUT_WIDTH-1:0] rd_data,
   output logic                   ovf_flag,
   output logic                   illegal_flag,
   input  logic                   clear_flags,
   output logic                   busy
);

   logic                   dValid_q, dValid_d;
   instr_t                 dInstr_q, dInstr_d;
   logic                   eValid_q, eValid_d;
   logic                   eWb_q, eWb_d;
   logic [2:0]             eRd_q, eRd_d;
   logic [INPUT_WIDTH-1:0] aluA_q, aluA_d;
   logic [INPUT_WIDTH-1:0] aluB_q, aluB_d;
   logic [3:0]             aluCop_q, aluCop_d;
   logic                   ovf_q, ovf_d;
   logic                   illegal_q, illegal_d;

   logic                   hazard;
   logic                   advance;
   logic                   eWriting;
   logic [INPUT_WIDTH-1:0] rfDataA, rfDataB;
   logic [INPUT_WIDTH-1:0] opA, opB;
   instr_t                 newInstr;
   logic                   unusedBits;

   assign unusedBits = ^instr_data[2:0];

   assign newInstr.cop = instr_data[COP_MSB:COP_LSB];
   assign newInstr.rd  = instr_data[RD_MSB:RD_LSB];
   assign newInstr.ra  = instr_data[RA_MSB:RA_LSB];
   assign newInstr.rb  = instr_data[RB_MSB:RB_LSB];

   assign eWriting = eValid_q && eWb_q;

   alu_issue_regfile #(
      .INPUT_WIDTH(INPUT_WIDTH),
      .NREGS      (NREGS)
   ) uRegfile (
      .clk        (clk),
      .reset      (reset),
      .writeEn_i  (eWriting),
      .writeAddr_i(eRd_q),
      .writeData_i(alu_result),
      .readAddrA_i(dInstr_q.ra),
      .readDataA_o(rfDataA),
      .readAddrB_i(dInstr_q.rb),
      .readDataB_o(rfDataB),
      .dbgAddr_i  (rd_addr),
      .dbgData_o  (rd_data)
   );

   // With forwarding the instruction in E hands its result straight to D's operands.
`ifdef ALU_ISSUE_FWD_EN
   assign hazard = 1'b0;
   assign opA    = (eWriting && (eRd_q == dInstr_q.ra)) ? alu_result : rfDataA;
   assign opB    = (eWriting && (eRd_q == dInstr_q.rb)) ? alu_result : rfDataB;
`else
   assign hazard = eWriting && ((eRd_q == dInstr_q.ra) || (eRd_q == dInstr_q.rb));
   assign opA    = rfDataA;
   assign opB    = rfDataB;
`endif

   assign advance     = dValid_q && !hazard;
   assign instr_ready = !dValid_q || advance;

   always_comb begin
      dValid_d  = dValid_q;
      dInstr_d  = dInstr_q;
      if (instr_valid && instr_ready) begin
         dValid_d = 1'b1;
         dInstr_d = newInstr;
      end else if (advance) begin
         dValid_d = 1'b0;
      end

      // A stalled or empty D leaves a bubble in E, which idles the ALU at zero.
      eValid_d = advance;
      eWb_d    = advance && is_legal_cop(dInstr_q.cop);
      eRd_d    = dInstr_q.rd;
      aluCop_d = advance ? dInstr_q.cop : COP_ZERO;
      aluA_d   = advance ? opA : '0;
      aluB_d   = advance ? opB : '0;

      ovf_d     = clear_flags ? 1'b0 : ovf_q;
      illegal_d = clear_flags ? 1'b0 : illegal_q;
      if (eWriting && alu_OVF) begin
         ovf_d = 1'b1;
      end
      if (eValid_q && !eWb_q) begin
         illegal_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dValid_q  <= 1'b0;
         dInstr_q  <= '0;
         eValid_q  <= 1'b0;
         eWb_q     <= 1'b0;
         eRd_q     <= '0;
         aluA_q    <= '0;
         aluB_q    <= '0;
         aluCop_q  <= COP_ZERO;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         dValid_q  <= dValid_d;
         dInstr_q  <= dInstr_d;
         eValid_q  <= eValid_d;
         eWb_q     <= eWb_d;
         eRd_q     <= eRd_d;
         aluA_q    <= aluA_d;
         aluB_q    <= aluB_d;
         aluCop_q  <= aluCop_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_reg_A    = aluA_q;
   assign alu_reg_B    = aluB_q;
   assign alu_cop      = aluCop_q;
   assign ovf_flag     = ovf_q;
   assign illegal_flag = illegal_q;
   assign busy         = dValid_q || eValid_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU stub; compile with
// ALU_ISSUE_FWD_EN defined to check the forwarding build.
module tb_alu_issue;
   import alu_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic [15:0]   instr_data;
   logic          instr_ready;
   logic [W-1:0]  alu_reg_A;
   logic [W-1:0]  alu_reg_B;
   logic [3:0]    alu_cop;
   logic [W-1:0]  alu_result;
   logic          alu_OVF;
   logic [2:0]    rd_addr;
   logic [W-1:0]  rd_data;
   logic          ovf_flag;
   logic          illegal_flag;
   logic          clear_flags;
   logic          busy;

   logic          seedEn;
   logic [W-1:0]  seedVal;
   logic [W:0]    aluWide;

   int compared   = 0;
   int mismatched = 0;
   int stalls;

`ifdef ALU_ISSUE_FWD_EN
   localparam int EXP_STALLS = 0;
`else
   localparam int EXP_STALLS = 1;
`endif

   always #5 clk = ~clk;

   alu_issue #(.INPUT_WIDTH(W), .NREGS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_ready (instr_ready),
      .alu_reg_A   (alu_reg_A),
      .alu_reg_B   (alu_reg_B),
      .alu_cop     (alu_cop),
      .alu_result  (alu_result),
      .alu_OVF     (alu_OVF),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .ovf_flag    (ovf_flag),
      .illegal_flag(illegal_flag),
      .clear_flags (clear_flags),
      .busy        (busy)
   );

   // ALU stub; seedEn lets the bench plant arbitrary register values.
   always_comb begin
      aluWide = '0;
      case (alu_cop)
         COP_ZERO:  aluWide = '0;
         COP_ADD:   aluWide = {1'b0, alu_reg_A} + {1'b0, alu_reg_B};
         COP_SUB:   aluWide = {1'b0, alu_reg_A} - {1'b0, alu_reg_B};
         COP_PASSB: aluWide = {1'b0, alu_reg_B};
         COP_EQ:    aluWide = (alu_reg_A == alu_reg_B) ? 17'd1 : 17'd0;
         COP_ADD6:  aluWide = {1'b0, alu_reg_A} + 17'd6;
         COP_ADD7:  aluWide = {1'b0, alu_reg_A} + 17'd7;
         COP_ADDE:  aluWide = {1'b0, alu_reg_A} + 17'd14;
         COP_ADDF:  aluWide = {1'b0, alu_reg_A} + 17'd15;
         default:   aluWide = 17'h1DEAD;
      endcase
      if (seedEn) begin
         aluWide = {1'b0, seedVal};
      end
   end

   assign alu_result = aluWide[W-1:0];
   assign alu_OVF    = aluWide[W];

   function automatic logic [15:0] mkInstr(input logic [3:0] cop, input logic [2:0] rd,
                                           input logic [2:0] ra, input logic [2:0] rb);
      return {cop, rd, ra, rb, 3'b000};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Presents one instruction from a negedge and returns at the negedge after it is taken.
   task automatic applyStimulus(input logic [15:0] instr);
      bit taken;
      taken       = 1'b0;
      instr_valid = 1'b1;
      instr_data  = instr;
      for (int i = 0; i < 10 && !taken; i++) begin
         if (instr_ready) taken = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      if (!taken) checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 20 && busy; i++) begin
         @(negedge clk);
      end
      if (busy) checkOutput("idleTimeout", 32'd1, 32'd0);
      @(negedge clk);
   endtask

   task automatic readCheck(input string tag, input logic [2:0] addr, input logic [W-1:0] exp);
      rd_addr = addr;
      #1;
      checkOutput(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic pulseClear();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
   endtask

   task automatic countStalls();
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         if (!instr_ready) stalls++;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr_data  = '0;
      rd_addr     = '0;
      clear_flags = 1'b0;
      seedEn      = 1'b0;
      seedVal     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      checkOutput("rstReady", 32'(instr_ready), 32'd1);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstCop", 32'(alu_cop), 32'd0);
      checkOutput("rstA", 32'(alu_reg_A), 32'd0);
      checkOutput("rstB", 32'(alu_reg_B), 32'd0);
      checkOutput("rstOvf", 32'(ovf_flag), 32'd0);
      checkOutput("rstIll", 32'(illegal_flag), 32'd0);
      readCheck("rstR3", 3'd3, 16'h0000);

      applyStimulus(mkInstr(COP_ADD, 3'd1, 3'd0, 3'd0));
      checkOutput("addBusy", 32'(busy), 32'd1);
      waitIdle();
      readCheck("addR1", 3'd1, 16'h0000);
      checkOutput("addOvf", 32'(ovf_flag), 32'd0);
      checkOutput("addIdle", 32'(busy), 32'd0);
      checkOutput("idleCop", 32'(alu_cop), 32'd0);

      seedEn  = 1'b1;
      seedVal = 16'hFFFF;
      applyStimulus(mkInstr(COP_PASSB, 3'd2, 3'd0, 3'd0));
      @(negedge clk);
      checkOutput("seedECop", 32'(alu_cop), 32'(COP_PASSB));
      readCheck("seedR2Early", 3'd2, 16'h0000);
      @(negedge clk);
      readCheck("seedR2", 3'd2, 16'hFFFF);
      seedVal = 16'h0001;
      applyStimulus(mkInstr(COP_PASSB, 3'd3, 3'd0, 3'd0));
      waitIdle();
      seedEn = 1'b0;
      readCheck("seedR3", 3'd3, 16'h0001);

      applyStimulus(mkInstr(COP_ADD, 3'd4, 3'd2, 3'd3));
      waitIdle();
      readCheck("addR4", 3'd4, 16'h0000);
      checkOutput("addCarryOvf", 32'(ovf_flag), 32'd1);
      pulseClear();
      checkOutput("clearOvf", 32'(ovf_flag), 32'd0);

      applyStimulus(mkInstr(COP_SUB, 3'd5, 3'd3, 3'd2));
      waitIdle();
      readCheck("subR5", 3'd5, 16'h0002);
      checkOutput("subBorrowOvf", 32'(ovf_flag), 32'd1);
      pulseClear();

      applyStimulus(mkInstr(COP_ADD, 3'd1, 3'd2, 3'd3));
      applyStimulus(mkInstr(COP_EQ, 3'd6, 3'd1, 3'd1));
      countStalls();
      checkOutput("depEqStalls", 32'(stalls), 32'(EXP_STALLS));
      waitIdle();
      readCheck("depEqR6", 3'd6, 16'h0001);

      applyStimulus(mkInstr(COP_ADD, 3'd1, 3'd3, 3'd3));
      applyStimulus(mkInstr(COP_ADD, 3'd6, 3'd1, 3'd3));
      countStalls();
      checkOutput("depAddStalls", 32'(stalls), 32'(EXP_STALLS));
      waitIdle();
      readCheck("depAddR1", 3'd1, 16'h0002);
      readCheck("depAddR6", 3'd6, 16'h0003);
      pulseClear();
      checkOutput("depOvfCleared", 32'(ovf_flag), 32'd0);

      applyStimulus(mkInstr(4'b1000, 3'd7, 3'd3, 3'd3));
      @(negedge clk);
      checkOutput("illECop", 32'(alu_cop), 32'h8);
      checkOutput("illEA", 32'(alu_reg_A), 32'h1);
      waitIdle();
      readCheck("illR7", 3'd7, 16'h0000);
      checkOutput("illFlag", 32'(illegal_flag), 32'd1);
      checkOutput("illNoOvf", 32'(ovf_flag), 32'd0);
      pulseClear();
      checkOutput("illCleared", 32'(illegal_flag), 32'd0);

      applyStimulus(mkInstr(4'b1001, 3'd7, 3'd0, 3'd0));
      @(negedge clk);
      pulseClear();
      checkOutput("illSetWins", 32'(illegal_flag), 32'd1);
      pulseClear();

      applyStimulus(mkInstr(COP_ADD, 3'd4, 3'd3, 3'd3));
      applyStimulus(mkInstr(COP_ADD, 3'd5, 3'd3, 3'd3));
      checkOutput("preRstBusy", 32'(busy), 32'd1);
      checkOutput("preRstECop", 32'(alu_cop), 32'(COP_ADD));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      checkOutput("midRstReady", 32'(instr_ready), 32'd1);
      checkOutput("midRstCop", 32'(alu_cop), 32'd0);
      checkOutput("midRstA", 32'(alu_reg_A), 32'd0);
      checkOutput("midRstB", 32'(alu_reg_B), 32'd0);
      checkOutput("midRstOvf", 32'(ovf_flag), 32'd0);
      readCheck("midRstR4", 3'd4, 16'h0000);
      readCheck("midRstR5", 3'd5, 16'h0000);
      @(negedge clk);
      readCheck("postRstR5", 3'd5, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
